// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the mux scan sequencer: default geometry, dwell
// default, counter width and the scan FSM state encoding.
package mux_scan_sequencer_pkg;

    localparam int N_CH_DEFAULT  = 32;
    localparam int SEL_W_DEFAULT = 5;
    localparam int DWELL_DEFAULT = 2;

    // Dwell counter width; covers the legal dwell range 1..15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } scan_state_e;

endpackage

// File: rtl/mux_scan_sequencer_next_set_finder.sv
// Combinational search for the lowest set mask bit strictly above from_idx.
// With from_below set the search starts below index 0, so bit 0 qualifies;
// this is how the first channel of a scan is located.
module next_set_finder
    import mux_scan_sequencer_pkg::*;
#(
    parameter int N_CH  = N_CH_DEFAULT,
    parameter int SEL_W = SEL_W_DEFAULT
) (
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] from_idx,
    input  logic             from_below,
    output logic [SEL_W-1:0] next_idx,
    output logic             found
);

    // Scan from the top down so the lowest qualifying index is the last write.
    always_comb begin
        next_idx = {SEL_W{1'b0}};
        found    = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i] && (from_below || (i > int'(from_idx)))) begin
                next_idx = SEL_W'(i);
                found    = 1'b1;
            end else begin
                next_idx = next_idx;
                found    = found;
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Mux scan sequencer: steps a registered select over the channels enabled in
// a captured mask, waits DWELL settle cycles after each select change, then
// samples the mux output into the result vector. All outputs are registered.
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int N_CH  = N_CH_DEFAULT,
    parameter int SEL_W = SEL_W_DEFAULT,
    parameter int DWELL = DWELL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_CH-1:0]  mask,
    input  logic             abort,
    input  logic             y_in,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             done,
    output logic [N_CH-1:0]  result
);

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);

    scan_state_e      state_r;
    scan_state_e      state_s;
    logic [N_CH-1:0]  mask_r;
    logic [N_CH-1:0]  mask_s;
    logic [SEL_W-1:0] sel_r;
    logic [SEL_W-1:0] sel_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [N_CH-1:0]  result_r;
    logic [N_CH-1:0]  result_s;
    logic             busy_r;
    logic             busy_s;
    logic             done_r;
    logic             done_s;

    logic [N_CH-1:0]  search_mask_s;
    logic             search_below_s;
    logic [SEL_W-1:0] next_idx_s;
    logic             found_s;

    // One finder serves both searches: in IDLE it looks at the live mask from
    // below channel 0; during a scan it looks above sel in the captured mask.
    always_comb begin
        if (state_r == ST_IDLE) begin
            search_mask_s  = mask;
            search_below_s = 1'b1;
        end else begin
            search_mask_s  = mask_r;
            search_below_s = 1'b0;
        end
    end

    next_set_finder #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_finder (
        .mask       (search_mask_s),
        .from_idx   (sel_r),
        .from_below (search_below_s),
        .next_idx   (next_idx_s),
        .found      (found_s)
    );

    // Next-state and next-datapath logic; everything holds unless changed.
    always_comb begin
        state_s  = state_r;
        mask_s   = mask_r;
        sel_s    = sel_r;
        cnt_s    = cnt_r;
        result_s = result_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    result_s = {N_CH{1'b0}};
                    if (found_s) begin
                        mask_s  = mask;
                        sel_s   = next_idx_s;
                        cnt_s   = DWELL_LOAD;
                        state_s = ST_SETTLE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = ST_SAMPLE;
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_SAMPLE: begin
                // The sample lands even when the scan is aborted this cycle.
                result_s[sel_r] = y_in;
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (found_s) begin
                    sel_s   = next_idx_s;
                    cnt_s   = DWELL_LOAD;
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s == ST_SETTLE) || (state_s == ST_SAMPLE);
        done_s = (state_r == ST_DONE);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r   <= {N_CH{1'b0}};
            sel_r    <= {SEL_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            result_r <= {N_CH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            mask_r   <= mask_s;
            sel_r    <= sel_s;
            cnt_r    <= cnt_s;
            result_r <= result_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign sel    = sel_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer. A behavioural 32:1 mux drives
// y_in from a per-test channel value vector. Expected select sequences,
// results and done latencies are queued when a scan is launched and checked
// when the DUT produces them.
module tb_mux_scan_sequencer;

    localparam int N_CH  = 32;
    localparam int SEL_W = 5;
    localparam int DWELL = 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic [N_CH-1:0]  mask;
    logic             abort;
    logic             y_in;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             done;
    logic [N_CH-1:0]  result;

    logic [N_CH-1:0]  chan_val;

    int tests_run;
    int tests_failed;

    int          sel_exp_q[$];
    logic [31:0] res_exp_q[$];
    int          lat_exp_q[$];

    logic             busy_d;
    logic [SEL_W-1:0] sel_d;

    mux_scan_sequencer #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W),
        .DWELL (DWELL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mask   (mask),
        .abort  (abort),
        .y_in   (y_in),
        .sel    (sel),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Behavioural downstream mux.
    assign y_in = chan_val[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Select monitor: each new select seen while busy must be the next queued one.
    always @(negedge clk) begin
        if (busy && (!busy_d || sel != sel_d)) begin
            if (sel_exp_q.size() > 0) begin
                check_val("sel_step", 32'(sel), 32'(sel_exp_q.pop_front()));
            end else begin
                check_val("sel_unexpected", 32'(sel), 32'hFFFF_FFFF);
            end
        end
        busy_d <= busy;
        sel_d  <= sel;
    end

    // Present start with mask; returns just after the accepting edge.
    task automatic launch(input logic [31:0] m);
        @(negedge clk);
        mask  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic queue_sels(input logic [31:0] m, output int k);
        k = 0;
        for (int i = 0; i < N_CH; i++) begin
            if (m[i]) begin
                sel_exp_q.push_back(i);
                k++;
            end
        end
    endtask

    // Full scan; optionally re-pulses start and flips mask mid-scan.
    task automatic run_scan(input logic [31:0] m, input logic [31:0] cv, input bit perturb);
        int k;
        int cyc;
        bit seen_done;
        bit busy_hit;
        chan_val = cv;
        queue_sels(m, k);
        res_exp_q.push_back(m & cv);
        lat_exp_q.push_back(k * (DWELL + 1) + 1);
        launch(m);
        cyc = 0;
        seen_done = 1'b0;
        busy_hit = 1'b0;
        while (!seen_done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy) busy_hit = 1'b1;
            if (perturb && cyc == 4) begin
                start = 1'b1;
                mask  = ~m;
            end
            if (perturb && cyc == 5) start = 1'b0;
            if (done) seen_done = 1'b1;
        end
        check_val("done_latency", 32'(cyc), 32'(lat_exp_q.pop_front()));
        check_val("result", result, res_exp_q.pop_front());
        @(posedge clk);
        #1;
        check_val("done_one_cycle", 32'(done), 32'd0);
        check_val("busy_after_done", 32'(busy), 32'd0);
        if (k == 0) check_val("busy_never_high", 32'(busy_hit), 32'd0);
        check_val("sel_queue_drained", 32'(sel_exp_q.size()), 32'd0);
    endtask

    initial begin
        int k;
        int done_hits;
        logic [31:0] rm;
        logic [31:0] rv;
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        mask     = 32'h0000_0000;
        chan_val = 32'h0000_0000;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_sel", 32'(sel), 32'd0);
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_done", 32'(done), 32'd0);
        check_val("reset_result", result, 32'd0);
        rst = 1'b0;

        // Three adjacent channels, ones on 0 and 2.
        run_scan(32'h0000_0007, 32'h0000_0005, 1'b0);
        // Result holds in IDLE.
        repeat (5) @(posedge clk);
        #1;
        check_val("result_hold", result, 32'h0000_0005);

        // Extremes of the channel range, both polarities on channel 31.
        run_scan(32'h8000_0001, 32'h8000_0000, 1'b0);
        run_scan(32'h8000_0001, 32'h0000_0001, 1'b0);

        // Empty mask.
        run_scan(32'h0000_0000, 32'hFFFF_FFFF, 1'b0);

        // Start re-pulse and mask change mid-scan.
        run_scan(32'h0000_0007, 32'h0000_0002, 1'b1);

        // Abort sampled at the eighth edge after start acceptance.
        chan_val = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) sel_exp_q.push_back(i);
        launch(32'hFFFF_FFFF);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_val("abort_busy", 32'(busy), 32'd0);
        done_hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) done_hits++;
        end
        check_val("abort_no_done", 32'(done_hits), 32'd0);
        check_val("abort_result", result, 32'h0000_0003);
        check_val("abort_sel_queue", 32'(sel_exp_q.size()), 32'd0);

        // Reset in the middle of a scan.
        chan_val = 32'hFFFF_FFFF;
        sel_exp_q.push_back(0);
        sel_exp_q.push_back(1);
        launch(32'hFFFF_FFFF);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check_val("pre_reset_result", result, 32'h0000_0001);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("midrst_sel", 32'(sel), 32'd0);
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_done", 32'(done), 32'd0);
        check_val("midrst_result", result, 32'd0);
        done_hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) done_hits++;
        end
        check_val("midrst_no_done", 32'(done_hits), 32'd0);
        run_scan(32'h0001_0100, 32'h0001_0000, 1'b0);

        // Full mask and a few random patterns.
        run_scan(32'hFFFF_FFFF, 32'hA5C3_0F96, 1'b0);
        for (int t = 0; t < 4; t++) begin
            rm = $urandom();
            rv = $urandom();
            run_scan(rm, rv, 1'b0);
        end

        // Abort while idle is ignored.
        abort = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b0;
        check_val("idle_abort_busy", 32'(busy), 32'd0);
        k = 0;
        run_scan(32'h0000_0010, 32'h0000_0010, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
